// File: rtl/synth_pkg.sv
// Shared types and constants for the note sequencer.
package synth_pkg;

    typedef enum logic [1:0] {IDLE, GATE, WAIT} state_t;

    localparam int NOTE_MAX = 127;
    localparam int NOTE_W   = 7;

    // Clamp a signed note sum into the playable 0..NOTE_MAX range.
    function automatic logic [NOTE_W-1:0] sat_note(input logic signed [9:0] v);
        logic [NOTE_W-1:0] r;
        if (v < 10'sd0)
            r = '0;
        else if (v > 10'sd127)
            r = NOTE_W'(NOTE_MAX);
        else
            r = v[NOTE_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/note_step_ram.sv
// Step table: one write port, one registered read port; contents survive reset.
module note_step_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          Clk,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [7:0]    wrData,
    input  logic [AW-1:0] rdAddr,
    output logic [7:0]    rdData
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (wrEn)
            mem[wrAddr] <= wrData;
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/note_player.sv
// Step sequencer: plays a NUM_STEPS note/rest table with gate timing.
// Optional transpose input compiled in with NOTE_PLAYER_TRANSPOSE_EN.
module note_player
    import synth_pkg::*;
#(
    parameter int NUM_STEPS = 16,
    parameter int CNT_W     = 24
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         play,
    input  logic                         stepWrEn,
    input  logic [$clog2(NUM_STEPS)-1:0] stepWrAddr,
    input  logic [NOTE_W-1:0]            stepWrNote,
    input  logic                         stepWrRest,
    input  logic [CNT_W-1:0]             tickPeriod,
    input  logic [CNT_W-1:0]             gateLen,
`ifdef NOTE_PLAYER_TRANSPOSE_EN
    input  logic [7:0]                   transpose,
`endif
    output logic                         noteTrig,
    output logic                         noteOff,
    output logic [31:0]                  noteIdx,
    output logic [$clog2(NUM_STEPS)-1:0] stepIdx,
    output logic                         playing
);

    localparam int AW = $clog2(NUM_STEPS);

    state_t           state;
    logic [CNT_W-1:0] cnt, tickQ, gateQ;
    logic [7:0]       rdData;
    logic [AW-1:0]    rdAddr, nextStep;
    logic             tickEnd, gateEnd, start, stop;
    logic [NOTE_W-1:0] loadNote;

    note_step_ram #(.DEPTH(NUM_STEPS), .AW(AW)) u_ram (
        .Clk    (Clk),
        .wrEn   (stepWrEn),
        .wrAddr (stepWrAddr),
        .wrData ({stepWrRest, stepWrNote}),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    always_comb begin
        tickEnd  = (cnt == tickQ - CNT_W'(1));
        gateEnd  = (state == GATE) && (cnt == gateQ - CNT_W'(1)) && (gateQ < tickQ);
        start    = play && ((state == IDLE) || tickEnd);
        stop     = !play && (state != IDLE);
        nextStep = (state == IDLE) ? '0 : stepIdx + AW'(1);
        // The read port always fetches the step after the one playing after
        // this edge, so back-to-back step starts find their data ready.
        if (Reset || stop)
            rdAddr = '0;
        else if (start)
            rdAddr = nextStep + AW'(1);
        else if (state == IDLE)
            rdAddr = '0;
        else
            rdAddr = stepIdx + AW'(1);
`ifdef NOTE_PLAYER_TRANSPOSE_EN
        loadNote = sat_note($signed({3'b000, rdData[NOTE_W-1:0]}) +
                            $signed({{2{transpose[7]}}, transpose}));
`else
        loadNote = rdData[NOTE_W-1:0];
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            tickQ    <= '0;
            gateQ    <= '0;
            noteTrig <= 1'b0;
            noteOff  <= 1'b0;
            noteIdx  <= '0;
            stepIdx  <= '0;
            playing  <= 1'b0;
        end else begin
            noteTrig <= 1'b0;
            noteOff  <= 1'b0;
            if (start) begin
                stepIdx <= nextStep;
                cnt     <= '0;
                tickQ   <= (tickPeriod == '0) ? CNT_W'(1) : tickPeriod;
                gateQ   <= (gateLen == '0) ? CNT_W'(1) : gateLen;
                playing <= 1'b1;
                if (rdData[7]) begin
                    state   <= WAIT;
                    noteOff <= (state == GATE);
                end else begin
                    state    <= GATE;
                    noteTrig <= 1'b1;
                    noteIdx  <= 32'(loadNote);
                end
            end else if (stop) begin
                state   <= IDLE;
                playing <= 1'b0;
                stepIdx <= '0;
                cnt     <= '0;
                noteOff <= (state == GATE);
            end else if (state != IDLE) begin
                cnt <= cnt + CNT_W'(1);
                if (gateEnd) begin
                    noteOff <= 1'b1;
                    state   <= WAIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: expected pulse events are queued per
// scenario and matched against observed noteTrig/noteOff pulses.
module tb_note_player;

    logic        Clk = 1'b0;
    logic        Reset, play, stepWrEn, stepWrRest;
    logic [3:0]  stepWrAddr;
    logic [6:0]  stepWrNote;
    logic [23:0] tickPeriod, gateLen;
    logic        noteTrig, noteOff, playing;
    logic [31:0] noteIdx;
    logic [3:0]  stepIdx;
`ifdef NOTE_PLAYER_TRANSPOSE_EN
    logic [7:0]  transpose;
`endif

    always #5 Clk = ~Clk;

    note_player dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .play       (play),
        .stepWrEn   (stepWrEn),
        .stepWrAddr (stepWrAddr),
        .stepWrNote (stepWrNote),
        .stepWrRest (stepWrRest),
        .tickPeriod (tickPeriod),
        .gateLen    (gateLen),
`ifdef NOTE_PLAYER_TRANSPOSE_EN
        .transpose  (transpose),
`endif
        .noteTrig   (noteTrig),
        .noteOff    (noteOff),
        .noteIdx    (noteIdx),
        .stepIdx    (stepIdx),
        .playing    (playing)
    );

    // rel: cycles since play was driven; trig=0 entries are noteOff events
    typedef struct {
        int rel;
        int trig;
        int idx;
        int step;
    } ev_t;

    ev_t sb[$];
    int  rel;
    int  n_vec = 0;
    int  n_err = 0;

    // Basic pattern 60,62,rest,64 with tick 8 / gate 4
    ev_t vA[6] = '{'{1, 1, 60, 0}, '{5, 0, 0, 0}, '{9, 1, 62, 1},
                   '{13, 0, 0, 0}, '{25, 1, 64, 3}, '{29, 0, 0, 0}};
    // Legato tick 8 / gate 10; rest releases; play drop in GATE at rel 27
    ev_t vB[5] = '{'{1, 1, 60, 0}, '{9, 1, 62, 1}, '{17, 0, 0, 0},
                   '{25, 1, 64, 3}, '{28, 0, 0, 0}};

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @rel %0d: got %0d, want %0d", name, rel, act, exp);
        end
    endtask

    task automatic tick();
        ev_t e;
        @(posedge Clk);
        rel++;
        @(negedge Clk);
        if (noteTrig || noteOff) begin
            chk("trig_off_overlap", int'(noteTrig & noteOff), 0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse_rel", rel, -1);
            end else begin
                e = sb.pop_front();
                chk("pulse_rel", rel, e.rel);
                chk("pulse_kind", int'(noteTrig), e.trig);
                if (e.trig != 0) begin
                    chk("note_idx", int'(noteIdx), e.idx);
                    chk("step_idx", int'(stepIdx), e.step);
                end
            end
        end
    endtask

    task automatic wr(input int a, input int n, input int r);
        stepWrEn   = 1'b1;
        stepWrAddr = 4'(a);
        stepWrNote = 7'(n);
        stepWrRest = r[0];
        @(posedge Clk);
        @(negedge Clk);
        stepWrEn   = 1'b0;
    endtask

    task automatic run(input string name, input int stopAt, input int endAt);
        rel  = 0;
        play = 1'b1;
        while (rel < endAt) begin
            if (rel == stopAt)
                play = 1'b0;
            tick();
        end
        chk({name, "_leftover"}, sb.size(), 0);
        chk({name, "_playing"}, int'(playing), 0);
        chk({name, "_stepidx"}, int'(stepIdx), 0);
        sb.delete();
    endtask

    task automatic idle(input int n);
        rel = -100;
        repeat (n) tick();
    endtask

    initial begin
        Reset      = 1'b1;
        play       = 1'b0;
        stepWrEn   = 1'b0;
        stepWrAddr = '0;
        stepWrNote = '0;
        stepWrRest = 1'b0;
        tickPeriod = '0;
        gateLen    = '0;
`ifdef NOTE_PLAYER_TRANSPOSE_EN
        transpose  = '0;
`endif
        repeat (3) @(negedge Clk);
        wr(0, 60, 0);
        wr(1, 62, 0);
        wr(2, 0, 1);
        wr(3, 64, 0);
        for (int i = 4; i < 16; i++) wr(i, 0, 1);
        rel = 0;
        chk("rst_trig", int'(noteTrig), 0);
        chk("rst_off", int'(noteOff), 0);
        chk("rst_idx", int'(noteIdx), 0);
        chk("rst_step", int'(stepIdx), 0);
        chk("rst_playing", int'(playing), 0);
        Reset = 1'b0;
        idle(2);

        // Gated notes with a rest; stop while released
        tickPeriod = 24'd8;
        gateLen    = 24'd4;
        for (int i = 0; i < 6; i++) sb.push_back(vA[i]);
        run("basic", 31, 34);
        idle(2);

        // Legato into a rest, then stop mid-note
        gateLen = 24'd10;
        for (int i = 0; i < 5; i++) sb.push_back(vB[i]);
        run("legato", 27, 30);
        idle(2);

        // Zero timing treated as 1: a step per cycle through the wrap
        for (int i = 0; i < 16; i++) wr(i, 40 + i, 0);
        idle(2);
        tickPeriod = '0;
        gateLen    = '0;
        for (int k = 0; k < 18; k++) sb.push_back('{k + 1, 1, 40 + (k % 16), k % 16});
        sb.push_back('{19, 0, 0, 0});
        run("wrap", 18, 21);
        idle(2);

        // Reset during GATE: outputs clear, no release pulse
        tickPeriod = 24'd8;
        gateLen    = 24'd4;
        sb.push_back('{1, 1, 40, 0});
        rel  = 0;
        play = 1'b1;
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        chk("midrst_trig", int'(noteTrig), 0);
        chk("midrst_off", int'(noteOff), 0);
        chk("midrst_idx", int'(noteIdx), 0);
        chk("midrst_step", int'(stepIdx), 0);
        chk("midrst_playing", int'(playing), 0);
        Reset = 1'b0;
        play  = 1'b0;
        repeat (6) tick();
        chk("midrst_leftover", sb.size(), 0);
        sb.delete();

`ifdef NOTE_PLAYER_TRANSPOSE_EN
        // Saturation at both ends of the note range
        wr(0, 120, 0);
        wr(1, 5, 0);
        idle(2);
        tickPeriod = 24'd4;
        gateLen    = 24'd2;
        transpose  = 8'd12;
        sb.push_back('{1, 1, 127, 0});
        sb.push_back('{3, 0, 0, 0});
        sb.push_back('{5, 1, 0, 1});
        sb.push_back('{7, 0, 0, 0});
        rel  = 0;
        play = 1'b1;
        while (rel < 10) begin
            if (rel == 2) transpose = 8'hF4;
            if (rel == 7) play = 1'b0;
            tick();
        end
        chk("xpose_leftover", sb.size(), 0);
        sb.delete();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 Parameter NUM_STEPS, default 16, sequence length in steps (power of two).
REQ-002 Parameter CNT_W, default 24, width of the step and gate timing counters.
REQ-003 Clk  input  1  sole clock; all state changes on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 play  input  1  level; high = sequence running, low = stopped.
REQ-006 stepWrEn  input  1  write strobe for the step table.
REQ-007 stepWrAddr  input  $clog2(NUM_STEPS)  step table write address.
REQ-008 stepWrNote  input  7  note index 0..127 written to that step.
REQ-009 stepWrRest  input  1  marks the written step as a rest.
REQ-010 tickPeriod  input  CNT_W  clocks per step; 0 is treated as 1.
REQ-011 gateLen  input  CNT_W  clocks a note is held; 0 is treated as 1.
REQ-012 noteTrig  output  1  one-cycle pulse: a new note starts at noteIdx.
REQ-013 noteOff  output  1  one-cycle pulse: the sounding note is released.
REQ-014 noteIdx  output  32 (int)  current note index, 0..127.
REQ-015 stepIdx  output  $clog2(NUM_STEPS)  step currently playing.
REQ-016 playing  output  1  high while the FSM is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, GATE (note sounding) and WAIT (released or rest).
- IDLE -> GATE when play is high and step 0 is a note.
- IDLE -> WAIT when play is high and step 0 is a rest.
REQ-018 At every step start the block SHALL clear the timing counter and load that step from the table.
- If the step is a note, noteIdx takes the note and noteTrig pulses.
- If the step is a rest, noteIdx holds its value.
REQ-019 noteTrig SHALL assert exactly one cycle after the step-start condition is sampled (registered outputs, latency 1).
REQ-020 In GATE, when counter == gateLen-1 and gateLen < tickPeriod: noteOff pulses and the FSM goes to WAIT.
REQ-021 When counter == tickPeriod-1 the block SHALL advance stepIdx, wrapping from NUM_STEPS-1 to 0.
- If gateLen >= tickPeriod (legato), no noteOff is issued between steps; the new noteTrig replaces the note.
REQ-022 A rest step SHALL pulse noteOff if a note is still sounding when the rest begins.
REQ-023 When play falls in GATE: noteOff pulses on the next cycle, the FSM enters IDLE and stepIdx resets to 0.
- When play falls in WAIT: the FSM enters IDLE with no pulse.
REQ-024 noteTrig and noteOff SHALL never assert in the same cycle.
REQ-025 A table write to the step currently being loaded SHALL take effect on the next pass; the step load uses the pre-write value.
REQ-026 tickPeriod and gateLen SHALL be sampled at every step start and held constant for that step.

Reset
REQ-027 Reset SHALL force:
- noteTrig=0, noteOff=0, noteIdx=0, stepIdx=0, playing=0;
- FSM=IDLE, counter=0.
REQ-028 Reset asserted mid-note SHALL NOT emit noteOff.
REQ-029 The step table SHALL NOT be cleared by reset.

Configuration
REQ-030 The feature is compiled in by the macro NOTE_PLAYER_TRANSPOSE_EN.
- Defined: adds input transpose (8-bit signed); noteIdx = step note + transpose, saturated to 0..127, sampled at step start.
- Undefined: port absent; noteIdx = step note.

Structure
REQ-031 Package synth_pkg SHALL hold the FSM state enum, NOTE_MAX=127 and NOTE_W=7.
REQ-032 The step table SHALL be the sub-module note_step_ram: NUM_STEPS x 8 bits (rest flag + note), one write port, one registered read port.

Verification
REQ-033 Steps 0..3 = 60,62,rest,64; tickPeriod=8, gateLen=4; play=1 -> noteTrig idx 60 at cycle 1, noteOff at cycle 5, noteTrig idx 62 at cycle 9, no trig in step 2, noteTrig idx 64 at cycle 25.
REQ-034 Legato: gateLen=10, tickPeriod=8 -> consecutive noteTrig pulses 8 cycles apart with no noteOff between them.
REQ-035 Stop mid-note: play drops 2 cycles after noteTrig -> a single noteOff next cycle, playing=0, stepIdx=0.
REQ-036 Wrap: NUM_STEPS=16, tickPeriod=1 -> stepIdx goes 15 -> 0 and step 0's note retriggers.
REQ-037 Reset asserted during GATE -> all outputs 0 the next cycle, no noteOff pulse.
REQ-038 With NOTE_PLAYER_TRANSPOSE_EN: note 120, transpose=+12 -> noteIdx=127; note 5, transpose=-12 -> noteIdx=0.
